// File: rtl/mem_wb_arb_pkg.sv
// mem_wb_arb_pkg
// Shared constants and types for the MEM/WB register and regfile write-port
// arbiter. Holds the register/bus widths, the active-low reset level, the
// stall-request level, and a helper that picks the write-port source.
package mem_wb_arb_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;

  localparam logic              RSTN_ENABLE   = 1'b0;
  localparam logic              STALL_REQ     = 1'b1;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;
  localparam logic [REG_W-1:0]  ZERO_WORD     = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR     = '0;

  // Which entry owns the regfile write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_P    = 2'd1,
    SRC_D    = 2'd2
  } wb_src_e;

  // The in-order pipeline entry always wins; the divide buffer only gets the
  // port in cycles where no pipeline write is pending.
  function automatic wb_src_e sel_src(input logic p_pend, input logic d_valid);
    if (p_pend) begin
      return SRC_P;
    end else if (d_valid) begin
      return SRC_D;
    end
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/mem_wb_arb_div_wbuf.sv
// div_wbuf
// One-entry buffer for out-of-order divide results plus the starvation age
// counter that raises a pipeline stall request when the entry is blocked.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   div_valid_i/waddr/wdata divide result offered by the divide unit
//   div_ready_o            entry is free; handshake when valid && ready
//   p_pend_i               pipeline entry owns the port this cycle (blocks D)
//   drain_i                D drove the write port this cycle; empty at edge
//   d_valid_o/waddr/wdata  buffered result towards the arbiter mux
//   stallreq_o             D has been blocked for AGE_MAX cycles
//
// Handshake: a result transfers at a rising edge when div_valid_i and
// div_ready_o are both high in the preceding cycle; div_ready_o never depends
// on div_valid_i.
module div_wbuf
  import mem_wb_arb_pkg::*;
#(
  parameter int AGE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              div_valid_i,
  input  logic [ADDR_W-1:0] div_waddr_i,
  input  logic [REG_W-1:0]  div_wdata_i,
  input  logic              p_pend_i,
  input  logic              drain_i,
  output logic              div_ready_o,
  output logic              d_valid_o,
  output logic [ADDR_W-1:0] d_waddr_o,
  output logic [REG_W-1:0]  d_wdata_o,
  output logic              stallreq_o
);

  localparam logic [1:0] AGE_SAT = AGE_MAX[1:0];

  logic              d_valid_q, d_valid_d;
  logic [ADDR_W-1:0] d_waddr_q, d_waddr_d;
  logic [REG_W-1:0]  d_wdata_q, d_wdata_d;
  logic [1:0]        age_q, age_d;
  logic              hs;

  // Ready is forced low during reset so no result is accepted then.
  assign div_ready_o = rst_ni && !d_valid_q;
  assign hs          = div_valid_i && div_ready_o;

  // drain_i implies d_valid_q and hs implies !d_valid_q, so the two branches
  // below can never both apply in one cycle.
  always_comb begin
    d_valid_d = d_valid_q;
    d_waddr_d = d_waddr_q;
    d_wdata_d = d_wdata_q;
    age_d     = age_q;
    if (drain_i) begin
      d_valid_d = 1'b0;
      age_d     = 2'd0;
    end else if (hs) begin
      // A result for r0 completes the handshake but is never written.
      d_valid_d = (div_waddr_i != ZERO_ADDR);
      d_waddr_d = div_waddr_i;
      d_wdata_d = div_wdata_i;
      age_d     = 2'd0;
    end else if (d_valid_q && p_pend_i && (age_q != AGE_SAT)) begin
      age_d = age_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RSTN_ENABLE) begin
      d_valid_q <= 1'b0;
      d_waddr_q <= ZERO_ADDR;
      d_wdata_q <= ZERO_WORD;
      age_q     <= 2'd0;
    end else begin
      d_valid_q <= d_valid_d;
      d_waddr_q <= d_waddr_d;
      d_wdata_q <= d_wdata_d;
      age_q     <= age_d;
    end
  end

  assign d_valid_o  = d_valid_q;
  assign d_waddr_o  = d_waddr_q;
  assign d_wdata_o  = d_wdata_q;
  assign stallreq_o = (d_valid_q && (age_q == AGE_SAT)) ? STALL_REQ : ~STALL_REQ;

endmodule

// File: rtl/mem_wb_arb.sv
// mem_wb_arb
// MEM/WB pipeline register and regfile write-port arbiter. Merges in-order
// MEM-stage results (entry P) with buffered divide results (entry D, in
// div_wbuf) onto the single regfile write port and counts committed writes.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   mem_wd/mem_wreg/mem_wdata     MEM-stage destination, enable, result
//   stall, flush                  pipeline control (flush has priority)
//   div_valid/div_waddr/div_wdata divide result offered
//   div_ready                     divide result accepted when valid && ready
//   wb_we/wb_waddr/wb_wdata       regfile write port
//   stallreq_wb                   stall request so the divide result drains
//   retire_cnt                    committed regfile writes, wraps at 2^32
module mem_wb_arb
  import mem_wb_arb_pkg::*;
#(
  parameter int AGE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [REG_W-1:0]  mem_wdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              div_valid,
  input  logic [ADDR_W-1:0] div_waddr,
  input  logic [REG_W-1:0]  div_wdata,
  output logic              div_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [REG_W-1:0]  wb_wdata,
  output logic              stallreq_wb,
  output logic [31:0]       retire_cnt
);

  logic              p_pend_q, p_pend_d;
  logic [ADDR_W-1:0] p_waddr_q, p_waddr_d;
  logic [REG_W-1:0]  p_wdata_q, p_wdata_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;

  logic              d_valid;
  logic [ADDR_W-1:0] d_waddr;
  logic [REG_W-1:0]  d_wdata;
  logic              drain;
  wb_src_e           src;

  assign src   = sel_src(p_pend_q, d_valid);
  assign drain = (src == SRC_D);

  div_wbuf #(
    .AGE_MAX (AGE_MAX)
  ) u_div_wbuf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .div_valid_i (div_valid),
    .div_waddr_i (div_waddr),
    .div_wdata_i (div_wdata),
    .p_pend_i    (p_pend_q),
    .drain_i     (drain),
    .div_ready_o (div_ready),
    .d_valid_o   (d_valid),
    .d_waddr_o   (d_waddr),
    .d_wdata_o   (d_wdata),
    .stallreq_o  (stallreq_wb)
  );

  always_comb begin
    wb_we    = WRITE_DISABLE;
    wb_waddr = ZERO_ADDR;
    wb_wdata = ZERO_WORD;
    case (src)
      SRC_P: begin
        wb_we    = WRITE_ENABLE;
        wb_waddr = p_waddr_q;
        wb_wdata = p_wdata_q;
      end
      SRC_D: begin
        wb_we    = WRITE_ENABLE;
        wb_waddr = d_waddr;
        wb_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // A pending P entry is always on the port, so under stall it has written
  // once by the end of the cycle and must not write again.
  always_comb begin
    p_pend_d  = p_pend_q;
    p_waddr_d = p_waddr_q;
    p_wdata_d = p_wdata_q;
    if (flush) begin
      p_pend_d = 1'b0;
    end else if (stall) begin
      if (p_pend_q) begin
        p_pend_d = 1'b0;
      end
    end else begin
      p_pend_d  = mem_wreg && (mem_wd != ZERO_ADDR);
      p_waddr_d = mem_wd;
      p_wdata_d = mem_wdata;
    end
  end

  assign retire_cnt_d = retire_cnt_q + {31'd0, wb_we};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      p_pend_q     <= 1'b0;
      p_waddr_q    <= ZERO_ADDR;
      p_wdata_q    <= ZERO_WORD;
      retire_cnt_q <= 32'd0;
    end else begin
      p_pend_q     <= p_pend_d;
      p_waddr_q    <= p_waddr_d;
      p_wdata_q    <= p_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule
